// File: rtl/time_manager.sv
// time_manager: emulated-time stepper.
// Picks the smallest pending step request (bounded by DT_MAX), optionally
// clamps it so emulated time never passes a stop time, and accumulates
// emulated time with saturation. States: IDLE (paused), RUN (stepping),
// HALT (stop time or saturation reached; waits for emu_run to drop).
module time_manager #(
    parameter int N_REQ      = 2,
    parameter int DT_WIDTH   = 27,
    parameter int TIME_WIDTH = 40,
    parameter int DT_MAX     = 2 ** (DT_WIDTH - 1) - 1
) (
    input  logic                      emu_clk,
    input  logic                      emu_rst_n,
    input  logic                      emu_run,
    input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
    input  logic                      tstop_en,
    input  logic [TIME_WIDTH-1:0]     tstop,
    output logic [DT_WIDTH-1:0]       emu_dt,
    output logic [DT_WIDTH-1:0]       neg_emu_dt,
    output logic [TIME_WIDTH-1:0]     emu_time,
    output logic                      emu_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [DT_WIDTH-1:0]   DT_LIMIT = DT_WIDTH'(DT_MAX);
    localparam logic [TIME_WIDTH-1:0] TIME_ALL = {TIME_WIDTH{1'b1}};

    logic [1:0]            state_q, state_d;
    logic [DT_WIDTH-1:0]   emu_dt_q, emu_dt_d;
    logic [DT_WIDTH-1:0]   neg_emu_dt_q, neg_emu_dt_d;
    logic [TIME_WIDTH-1:0] emu_time_q, emu_time_d;

    logic [TIME_WIDTH:0]   time_sum;
    logic [TIME_WIDTH-1:0] t_next;
    logic                  t_sat;
    logic [DT_WIDTH-1:0]   cand;
    logic [TIME_WIDTH-1:0] rem;
    logic [TIME_WIDTH-1:0] cand_wide;

    // Next time is current time plus the step applied this cycle, pinned at all-ones on overflow.
    always_comb begin
        time_sum = {1'b0, emu_time_q} + {{(TIME_WIDTH + 1 - DT_WIDTH){1'b0}}, emu_dt_q};
        t_next   = time_sum[TIME_WIDTH] ? TIME_ALL : time_sum[TIME_WIDTH-1:0];
        t_sat    = (t_next == TIME_ALL);
    end

    // Candidate step is the smallest request, never larger than DT_LIMIT.
    always_comb begin
        cand = DT_LIMIT;
        for (int i = 0; i < N_REQ; i++) begin
            if (dt_req[i*DT_WIDTH +: DT_WIDTH] < cand) begin
                cand = dt_req[i*DT_WIDTH +: DT_WIDTH];
            end
        end
        cand_wide = {{(TIME_WIDTH - DT_WIDTH){1'b0}}, cand};
        rem       = (tstop > t_next) ? (tstop - t_next) : '0;
    end

    // State transitions and the step to apply next cycle; time always advances by the current step.
    always_comb begin
        state_d    = state_q;
        emu_dt_d   = '0;
        emu_time_d = t_next;
        case (state_q)
            ST_IDLE: begin
                if (emu_run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (t_sat) begin
                    state_d = ST_HALT;
                end else if (!emu_run) begin
                    state_d = ST_IDLE;
                end else if (tstop_en) begin
                    if (rem == '0) begin
                        state_d = ST_HALT;
                    end else if (rem < cand_wide) begin
                        emu_dt_d = rem[DT_WIDTH-1:0];
                    end else begin
                        emu_dt_d = cand;
                    end
                end else begin
                    emu_dt_d = cand;
                end
            end
            ST_HALT: begin
                if (!emu_run) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        neg_emu_dt_d = (~emu_dt_d) + DT_WIDTH'(1);
    end

    // Register state, step, negated step and time; reset clears everything back to IDLE at zero.
    always_ff @(posedge emu_clk) begin
        if (!emu_rst_n) begin
            state_q      <= ST_IDLE;
            emu_dt_q     <= '0;
            neg_emu_dt_q <= '0;
            emu_time_q   <= '0;
        end else begin
            state_q      <= state_d;
            emu_dt_q     <= emu_dt_d;
            neg_emu_dt_q <= neg_emu_dt_d;
            emu_time_q   <= emu_time_d;
        end
    end

    assign emu_dt     = emu_dt_q;
    assign neg_emu_dt = neg_emu_dt_q;
    assign emu_time   = emu_time_q;
    assign emu_done   = (state_q == ST_HALT);

endmodule
